hummingbird2_core: RTL and testbench
====================================

Name: hummingbird2_core

Overview:
Parametrised next-generation accumulator CPU core with a 12-bit address space and 4-bit opcodes.
- Runs a small microsequenced fetch/execute machine against an external memory port that has a ready handshake, so wait states are supported.
- Adds a hardware call/return stack, stack fault detection, and a parametrised memory-mapped I/O port bank.
- Sits between program/data memory and board I/O, as the top-level core of the next board revision.

Parameters:
DATA_W, 8, accumulator/data word width (>=8); instructions occupy bits [7:0] of a word.
STACK_DEPTH, 4, call-stack entries (1..16), each 12 bits.
N_ODEV, 2, number of output port registers (1..8).
N_IDEV, 1, number of input ports (1..8).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
mem_req  out  1  memory request; held high until accepted.
mem_we  out  1  1=write, 0=read; valid while mem_req.
mem_addr  out  12  memory address; valid while mem_req.
mem_wdata  out  DATA_W  write data; valid while mem_req&&mem_we.
mem_rdata  in  DATA_W  read data; sampled on the edge where mem_req&&mem_ready.
mem_ready  in  1  transfer completes on the edge where mem_req&&mem_ready.
in_idev  in  N_IDEV*DATA_W  input ports; port k is slice k.
out_odev  out  N_ODEV*DATA_W  registered output ports.
pc_out  out  12  program counter.
acc_out  out  DATA_W  accumulator.
halted  out  1  core stopped (HLT executed or fault).
fault  out  2  00 none, 01 stack overflow, 10 stack underflow.

Behaviour:
- Reset: pc=0, acc=0, C=0, Z=0, sp=0, out_odev=0, mem_req=0, halted=0, fault=00, state=FETCH. Reset mid-transaction drops mem_req in the next cycle; no partial write is retried.
- States:
  - FETCH: read at pc; on accept IR<=rdata[7:0], pc<=pc+1 (12-bit wrap FFF->000).
  - Then 1-word ops -> EXEC; 2-word ops -> OPND.
  - OPND: read at pc; on accept ADR<={IR[3:0],rdata[7:0]}, pc<=pc+1; jump/call complete here, others -> MEM.
  - MEM: data read/write at ADR; on accept, execute, then -> FETCH.
  - EXEC: 1-word ops execute in one cycle, then -> FETCH.
  - HALT: absorbing until rst.
- Opcodes (IR[7:4]); imm = sign-extend IR[3:0] to DATA_W:
  - 0 NOP.
  - 1 LDI: A<=imm, Z updated.
  - 2 ADDI: A<=A+imm, C and Z updated.
  - 3 LD: A<=M, Z updated.
  - 4 ST: M<=A.
  - 5 ADD: A<=A+M, C and Z updated.
  - 6 SUB: A<=A-M; C=1 when no borrow; Z updated.
  - 7 AND, 8 OR, 9 XOR: A<=A op M; Z updated, C unchanged.
  - A JMP; B JZ (taken if Z); C JC (taken if C): pc<=ADR when taken.
  - D CALL: push pc (return address), then pc<=ADR.
  - E RET: pop into pc.
  - F HLT.
- Flags: C is the carry out of bit DATA_W-1; Z=(result==0). Flags not listed for an opcode hold their value.
- Zero-wait cycle counts: 1-word=2, jump/call=2, memory ops=3. Each wait cycle (mem_ready=0) adds exactly one cycle, and all request outputs stay stable through it.
- Stack:
  - CALL with sp==STACK_DEPTH: no push, pc unchanged, fault=01, -> HALT.
  - RET with sp==0: fault=10, -> HALT.
  - Fault and halted are sticky until rst.
- No request is issued in HALT.

Optional Feature:
IO_MAP_EN.
- Defined: addresses F00-FFF are internal and never reach the memory bus.
  - ST to F00+k (k<N_ODEV) loads out_odev slice k.
  - LD from F80+k (k<N_IDEV) returns in_idev slice k.
  - Other addresses in F00-FFF: writes are ignored, reads return 0.
  - Each internal access takes 1 cycle in MEM with mem_req=0.
- Undefined: all addresses go to the memory bus; out_odev is tied to 0 and in_idev is unused.

Test Plan:
- Reset, then program {LDI 5; ADDI -1; HLT}, mem_ready=1 -> acc=4, C=1, Z=0, halted=1 after 7 cycles, pc=3.
- LDI 7; ST 0x123; LDI 0; LD 0x123, with mem_ready low 2 cycles on every access -> bus write addr 123 data 07, acc=07; mem_req/addr/we stable through every wait.
- acc=FF; ADD of memory value 01 -> acc=00, C=1, Z=1; then JZ 0x040 taken (pc=040) and JC 0x080 taken; with C=0 and Z=0 both fall through to pc+2.
- Nested CALLs to depth STACK_DEPTH then matching RETs -> returns land at each call site +2. One extra CALL -> fault=01, halted=1, no further mem_req.
- RET with an empty stack -> fault=10, halted=1; rst asserted one cycle -> all outputs back to reset values and fetch restarts from 000.
- With IO_MAP_EN: ST F01 of 0x5A -> out_odev slice 1=5A with no mem_req; in_idev0=0x3C then LD F80 -> acc=3C. Without IO_MAP_EN: same ST appears on the bus with addr F01.

Source files
------------

// File: rtl/hummingbird2_core_if.sv
// Memory bus between hummingbird2_core (master) and program/data memory (slave).
// A transfer completes on the rising edge where mem_req && mem_ready.
interface hummingbird2_core_if #(
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [11:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/hummingbird2_core.sv
// hummingbird2_core: microsequenced accumulator CPU, 12-bit addresses, call stack, port bank.
// Define IO_MAP_EN to decode F00-FFF internally as output/input ports instead of the bus.
module hummingbird2_core #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int N_ODEV      = 2,
    parameter int N_IDEV      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    hummingbird2_core_if.master      bus,
    input  logic [N_IDEV*DATA_W-1:0] in_idev,
    output logic [N_ODEV*DATA_W-1:0] out_odev,
    output logic [11:0]              pc_out,
    output logic [DATA_W-1:0]        acc_out,
    output logic                     halted,
    output logic [1:0]               fault
);
    typedef enum logic [2:0] {S_FETCH, S_OPND, S_MEM, S_EXEC, S_HALT} state_e;
    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_ADDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND,
        OP_OR, OP_XOR, OP_JMP, OP_JZ, OP_JC, OP_CALL, OP_RET, OP_HLT
    } op_e;

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    state_e              state_q, state_d;
    logic [11:0]         pc_q, adr_q;
    logic [7:0]          ir_q;
    logic [DATA_W-1:0]   acc_q;
    logic                c_q, z_q, req_en_q;
    logic [SP_W-1:0]     sp_q;
    logic [11:0]         stack_q [2**SP_W];
    logic [1:0]          fault_q;

    op_e                 op;
    logic                accept, is_io, mem_done, stack_full, stack_empty, two_word;
    logic                alu_wr, c_d;
    logic [DATA_W-1:0]   imm, io_rdata, opnd, res;
    logic [11:0]         target;

    function automatic logic [DATA_W:0] add_c(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              cin);
        return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    endfunction

    assign op          = op_e'(ir_q[7:4]);
    assign imm         = {{(DATA_W-4){ir_q[3]}}, ir_q[3:0]};
    assign target      = {ir_q[3:0], bus.mem_rdata[7:0]};
    assign two_word    = (bus.mem_rdata[7:4] >= 4'h3) && (bus.mem_rdata[7:4] <= 4'hD);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign accept      = bus.mem_req && bus.mem_ready;
    assign mem_done    = (state_q == S_MEM) && (is_io || accept);
    assign opnd        = is_io ? io_rdata : bus.mem_rdata;

    // Request outputs depend only on registered state, so they hold steady through wait states
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc_q;
        bus.mem_wdata = acc_q;
        case (state_q)
            S_FETCH, S_OPND: bus.mem_req = req_en_q;
            S_MEM: begin
                bus.mem_req  = req_en_q && !is_io;
                bus.mem_we   = (op == OP_ST);
                bus.mem_addr = adr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [DATA_W:0] sum;
        sum    = '0;
        res    = acc_q;
        c_d    = c_q;
        alu_wr = 1'b0;
        case (op)
            OP_LDI:  begin res = imm; alu_wr = 1'b1; end
            OP_ADDI: begin sum = add_c(acc_q, imm, 1'b0); res = sum[DATA_W-1:0]; c_d = sum[DATA_W]; alu_wr = 1'b1; end
            OP_LD:   begin res = opnd; alu_wr = 1'b1; end
            OP_ADD:  begin sum = add_c(acc_q, opnd, 1'b0); res = sum[DATA_W-1:0]; c_d = sum[DATA_W]; alu_wr = 1'b1; end
            OP_SUB:  begin sum = add_c(acc_q, ~opnd, 1'b1); res = sum[DATA_W-1:0]; c_d = sum[DATA_W]; alu_wr = 1'b1; end
            OP_AND:  begin res = acc_q & opnd; alu_wr = 1'b1; end
            OP_OR:   begin res = acc_q | opnd; alu_wr = 1'b1; end
            OP_XOR:  begin res = acc_q ^ opnd; alu_wr = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (accept) state_d = two_word ? S_OPND : S_EXEC;
            S_OPND: if (accept) begin
                if (op == OP_CALL && stack_full)
                    state_d = S_HALT;
                else if (op inside {OP_JMP, OP_JZ, OP_JC, OP_CALL})
                    state_d = S_FETCH;
                else
                    state_d = S_MEM;
            end
            S_MEM:  if (mem_done) state_d = S_FETCH;
            S_EXEC: state_d = (op == OP_HLT || (op == OP_RET && stack_empty)) ? S_HALT : S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // req_en_q keeps the bus quiet for the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            sp_q     <= '0;
            fault_q  <= 2'b00;
            req_en_q <= 1'b0;
        end else begin
            req_en_q <= 1'b1;
            if (alu_wr && (state_q == S_EXEC || mem_done)) begin
                acc_q <= res;
                c_q   <= c_d;
                z_q   <= (res == '0);
            end
            case (state_q)
                S_FETCH: if (accept) pc_q <= pc_q + 12'd1;
                S_OPND: if (accept) begin
                    case (op)
                        OP_JMP:  pc_q <= target;
                        OP_JZ:   pc_q <= z_q ? target : pc_q + 12'd1;
                        OP_JC:   pc_q <= c_q ? target : pc_q + 12'd1;
                        OP_CALL: begin
                            if (stack_full) begin
                                fault_q <= 2'b01;
                            end else begin
                                pc_q <= target;
                                sp_q <= sp_q + 1'b1;
                            end
                        end
                        default: pc_q <= pc_q + 12'd1;
                    endcase
                end
                S_EXEC: if (op == OP_RET) begin
                    if (stack_empty) begin
                        fault_q <= 2'b10;
                    end else begin
                        pc_q <= stack_q[sp_q - 1'b1];
                        sp_q <= sp_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && accept)
            ir_q <= bus.mem_rdata[7:0];
        if (state_q == S_OPND && accept) begin
            adr_q <= target;
            if (op == OP_CALL && !stack_full)
                stack_q[sp_q] <= pc_q + 12'd1;
        end
    end

`ifdef IO_MAP_EN
    logic [N_ODEV*DATA_W-1:0] odev_q;

    assign is_io = (state_q == S_MEM) && (adr_q[11:8] == 4'hF);

    always_comb begin
        io_rdata = '0;
        for (int k = 0; k < N_IDEV; k++)
            if (adr_q[7:0] == 8'(8'h80 + k))
                io_rdata = in_idev[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst)
            odev_q <= '0;
        else if (is_io && op == OP_ST)
            for (int k = 0; k < N_ODEV; k++)
                if (adr_q[7:0] == 8'(k))
                    odev_q[k*DATA_W +: DATA_W] <= acc_q;
    end

    assign out_odev = odev_q;
`else
    logic unused_idev;

    assign is_io       = 1'b0;
    assign io_rdata    = '0;
    assign unused_idev = ^in_idev;
    assign out_odev    = '0;
`endif

    assign pc_out  = pc_q;
    assign acc_out = acc_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
endmodule

// File: tb/tb_hummingbird2_core.sv
// Directed bench for hummingbird2_core: behavioural memory with programmable wait states.
// Exercises the IO_MAP_EN variant when that macro is defined.
module tb_hummingbird2_core;
    localparam int DATA_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int N_ODEV      = 2;
    localparam int N_IDEV      = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_IDEV*DATA_W-1:0] in_idev;
    logic [N_ODEV*DATA_W-1:0] out_odev;
    logic [11:0]              pc_out;
    logic [DATA_W-1:0]        acc_out;
    logic                     halted;
    logic [1:0]               fault;

    hummingbird2_core_if #(.DATA_W(DATA_W)) bus ();

    hummingbird2_core #(
        .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH), .N_ODEV(N_ODEV), .N_IDEV(N_IDEV)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .in_idev(in_idev), .out_odev(out_odev),
        .pc_out(pc_out), .acc_out(acc_out), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [4096];
    assign bus.mem_rdata = mem[bus.mem_addr];

    int                n_cmp, n_fail;
    int                n_wait, wait_cnt, wr_cnt, req_cnt, stab_err, cyc;
    logic              prev_wait, p_we;
    logic [11:0]       p_addr, last_wa;
    logic [DATA_W-1:0] p_wdata, last_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ready at the falling edge, then account the transfer at the rising edge
    task automatic tick();
        logic              req_s, we_s;
        logic [11:0]       addr_s;
        logic [DATA_W-1:0] wdata_s;
        @(negedge clk);
        bus.mem_ready = (wait_cnt >= n_wait);
        req_s   = bus.mem_req;
        we_s    = bus.mem_we;
        addr_s  = bus.mem_addr;
        wdata_s = bus.mem_wdata;
        if (prev_wait && (!req_s || addr_s != p_addr || we_s != p_we || (we_s && wdata_s != p_wdata)))
            stab_err++;
        prev_wait = req_s && !bus.mem_ready;
        p_addr    = addr_s;
        p_we      = we_s;
        p_wdata   = wdata_s;
        @(posedge clk);
        if (req_s && bus.mem_ready) begin
            if (we_s) begin
                mem[addr_s] = wdata_s;
                wr_cnt++;
                last_wa = addr_s;
                last_wd = wdata_s;
            end
            wait_cnt = 0;
        end else if (req_s) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        if (req_s) req_cnt++;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[12'(i)] = '0;
    endtask

    task automatic put(input logic [11:0] a, input logic [7:0] b);
        mem[a] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        wait_cnt  = 0;
        prev_wait = 1'b0;
        wr_cnt    = 0;
        req_cnt   = 0;
        stab_err  = 0;
    endtask

    task automatic run_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic load_call_chain(input logic [7:0] last_hi, input logic [7:0] last_lo);
        clear_mem();
        put(12'h000, 8'hD1); put(12'h001, 8'h00); put(12'h002, 8'h21); put(12'h003, 8'hF0);
        put(12'h100, 8'hD2); put(12'h101, 8'h00); put(12'h102, 8'h21); put(12'h103, 8'hE0);
        put(12'h200, 8'hD3); put(12'h201, 8'h00); put(12'h202, 8'h21); put(12'h203, 8'hE0);
        put(12'h300, 8'hD4); put(12'h301, 8'h00); put(12'h302, 8'h21); put(12'h303, 8'hE0);
        put(12'h400, last_hi); put(12'h401, last_lo);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; n_wait = 0; wait_cnt = 0; wr_cnt = 0; req_cnt = 0; stab_err = 0;
        prev_wait = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; last_wa = '0; last_wd = '0;
        rst = 1'b1; in_idev = '0; bus.mem_ready = 1'b1;

        // Reset state, then LDI 5; ADDI -1; HLT with zero waits
        clear_mem();
        put(12'h000, 8'h15); put(12'h001, 8'h2F); put(12'h002, 8'hF0);
        do_reset();
        chk("rst_pc",     32'(pc_out), 32'h0);
        chk("rst_acc",    32'(acc_out), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault",  32'(fault), 32'h0);
        chk("rst_req",    32'(bus.mem_req), 32'h0);
        chk("rst_odev",   32'(out_odev), 32'h0);
        repeat (6) tick();
        chk("t1_running_at_6", 32'(halted), 32'h0);
        tick();
        chk("t1_halted_at_7", 32'(halted), 32'h1);
        chk("t1_acc",   32'(acc_out), 32'h4);
        chk("t1_pc",    32'(pc_out), 32'h3);
        chk("t1_fault", 32'(fault), 32'h0);
        req_cnt = 0;
        repeat (5) tick();
        chk("t1_no_req_in_halt", 32'(req_cnt), 32'h0);

        // LDI 7; ST 123; LDI 0; LD 123; HLT with two wait cycles per access
        clear_mem();
        put(12'h000, 8'h17); put(12'h001, 8'h41); put(12'h002, 8'h23);
        put(12'h003, 8'h10); put(12'h004, 8'h31); put(12'h005, 8'h23); put(12'h006, 8'hF0);
        put(12'h123, 8'hAA);
        n_wait = 2;
        do_reset();
        run_halt(200, cyc);
        chk("t2_halted",   32'(halted), 32'h1);
        chk("t2_cycles",   32'(cyc), 32'd31);
        chk("t2_acc",      32'(acc_out), 32'h07);
        chk("t2_pc",       32'(pc_out), 32'h007);
        chk("t2_wr_count", 32'(wr_cnt), 32'h1);
        chk("t2_wr_addr",  32'(last_wa), 32'h123);
        chk("t2_wr_data",  32'(last_wd), 32'h07);
        chk("t2_mem_123",  32'(mem[12'h123]), 32'h07);
        chk("t2_req_cycles", 32'(req_cnt), 32'd27);
        chk("t2_req_stable", 32'(stab_err), 32'h0);
        n_wait = 0;

        // ADD carry/zero, JZ and JC taken, then both fall through with C=0 Z=0
        clear_mem();
        put(12'h000, 8'h1F); put(12'h001, 8'h50); put(12'h002, 8'h30);
        put(12'h003, 8'hB0); put(12'h004, 8'h40); put(12'h005, 8'hF0);
        put(12'h030, 8'h01);
        put(12'h040, 8'hC0); put(12'h041, 8'h80); put(12'h042, 8'hF0);
        put(12'h080, 8'h21); put(12'h081, 8'hB0); put(12'h082, 8'hC0);
        put(12'h083, 8'hC0); put(12'h084, 8'hC0); put(12'h085, 8'hF0);
        put(12'h0C0, 8'hF0);
        do_reset();
        repeat (8) tick();
        chk("t3_jz_taken_pc", 32'(pc_out), 32'h040);
        chk("t3_add_acc",     32'(acc_out), 32'h00);
        repeat (2) tick();
        chk("t3_jc_taken_pc", 32'(pc_out), 32'h080);
        run_halt(100, cyc);
        chk("t3_halted",        32'(halted), 32'h1);
        chk("t3_cycles",        32'(cyc), 32'd8);
        chk("t3_fallthrough_pc", 32'(pc_out), 32'h086);
        chk("t3_acc",           32'(acc_out), 32'h01);

        // Nested calls to full depth and matching returns
        load_call_chain(8'hE0, 8'h00);
        do_reset();
        repeat (9) tick();
        chk("t4_deepest_pc", 32'(pc_out), 32'h400);
        run_halt(200, cyc);
        chk("t4_halted", 32'(halted), 32'h1);
        chk("t4_cycles", 32'(cyc), 32'd18);
        chk("t4_acc",    32'(acc_out), 32'h04);
        chk("t4_pc",     32'(pc_out), 32'h004);
        chk("t4_fault",  32'(fault), 32'h0);

        // One call past full depth
        load_call_chain(8'hD5, 8'h00);
        do_reset();
        run_halt(200, cyc);
        chk("t4o_halted", 32'(halted), 32'h1);
        chk("t4o_cycles", 32'(cyc), 32'd11);
        chk("t4o_fault",  32'(fault), 32'h1);
        req_cnt = 0;
        repeat (8) tick();
        chk("t4o_no_req",       32'(req_cnt), 32'h0);
        chk("t4o_fault_sticky", 32'(fault), 32'h1);

        // RET on empty stack, then one-cycle reset restarts fetch at 000
        clear_mem();
        put(12'h000, 8'h13); put(12'h001, 8'hE0);
        do_reset();
        run_halt(100, cyc);
        chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_cycles", 32'(cyc), 32'd5);
        chk("t5_fault",  32'(fault), 32'h2);
        chk("t5_acc",    32'(acc_out), 32'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_pc",     32'(pc_out), 32'h0);
        chk("t5_rst_acc",    32'(acc_out), 32'h0);
        chk("t5_rst_halted", 32'(halted), 32'h0);
        chk("t5_rst_fault",  32'(fault), 32'h0);
        chk("t5_rst_req",    32'(bus.mem_req), 32'h0);
        tick();
        chk("t5_refetch_req",  32'(bus.mem_req), 32'h1);
        chk("t5_refetch_addr", 32'(bus.mem_addr), 32'h000);
        chk("t5_refetch_we",   32'(bus.mem_we), 32'h0);

        // LD 050; ST F01; LDI 0; LD F80; HLT
        clear_mem();
        put(12'h000, 8'h30); put(12'h001, 8'h50); put(12'h002, 8'h4F); put(12'h003, 8'h01);
        put(12'h004, 8'h10); put(12'h005, 8'h3F); put(12'h006, 8'h80); put(12'h007, 8'hF0);
        put(12'h050, 8'h5A); put(12'hF80, 8'h77);
        in_idev = 8'h3C;
        do_reset();
        run_halt(100, cyc);
        chk("t6_halted", 32'(halted), 32'h1);
        chk("t6_cycles", 32'(cyc), 32'd14);
        chk("t6_pc",     32'(pc_out), 32'h008);
`ifdef IO_MAP_EN
        chk("t6_odev",     32'(out_odev), 32'h5A00);
        chk("t6_no_write", 32'(wr_cnt), 32'h0);
        chk("t6_acc_idev", 32'(acc_out), 32'h3C);
`else
        chk("t6_odev_tied", 32'(out_odev), 32'h0);
        chk("t6_wr_count",  32'(wr_cnt), 32'h1);
        chk("t6_wr_addr",   32'(last_wa), 32'hF01);
        chk("t6_wr_data",   32'(last_wd), 32'h5A);
        chk("t6_acc_mem",   32'(acc_out), 32'h77);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
